// File: rtl/riscv_alu_exec.sv
// riscv_alu_exec: valid/ready ALU execute unit, 1-cycle logic/arith, 1-bit/cycle shifts.
// Define SHIFT_BARREL_EN to compute shifts in a single cycle instead.
module riscv_alu_exec #(
   parameter int XLEN = 32,
   parameter int OP_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            illegal,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [OP_W-1:0] OP_AND  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_XOR  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_SLL  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_SLT  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_SLTU = OP_W'(7);
   localparam logic [OP_W-1:0] OP_SRL  = OP_W'(8);
   localparam logic [OP_W-1:0] OP_SRA  = OP_W'(9);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] res_q, res_d;
   logic            ill_q, ill_d;

   logic is_and, is_or, is_add, is_xor, is_sll;
   logic is_slt, is_sub, is_sltu, is_srl, is_sra;
   logic is_legal;

   always_comb begin
      is_and   = (op == OP_AND);
      is_or    = (op == OP_OR);
      is_add   = (op == OP_ADD);
      is_xor   = (op == OP_XOR);
      is_sll   = (op == OP_SLL);
      is_slt   = (op == OP_SLT);
      is_sub   = (op == OP_SUB);
      is_sltu  = (op == OP_SLTU);
      is_srl   = (op == OP_SRL);
      is_sra   = (op == OP_SRA);
      is_legal = is_and | is_or | is_add | is_xor | is_sll
               | is_slt | is_sub | is_sltu | is_srl | is_sra;
   end

   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] sum, diff;
   logic            lt_s, lt_u;

   assign shamt = b[SHW-1:0];
   assign sum   = a + b;
   assign diff  = a - b;
   assign lt_s  = $signed(a) < $signed(b);
   assign lt_u  = a < b;

   logic [XLEN-1:0] alu_res;

   always_comb begin
      alu_res = '0;
      unique case (1'b1)
         is_and:  alu_res = a & b;
         is_or:   alu_res = a | b;
         is_add:  alu_res = sum;
         is_xor:  alu_res = a ^ b;
         is_sub:  alu_res = diff;
         is_slt:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
         is_sltu: alu_res = {{(XLEN-1){1'b0}}, lt_u};
`ifdef SHIFT_BARREL_EN
         is_sll:  alu_res = a << shamt;
         is_srl:  alu_res = a >> shamt;
         is_sra:  alu_res = $unsigned($signed(a) >>> shamt);
`else
         // iterative shifter starts from the unshifted operand
         is_sll, is_srl, is_sra: alu_res = a;
`endif
         default: alu_res = '0;
      endcase
   end

`ifndef SHIFT_BARREL_EN
   typedef enum logic [1:0] {
      SH_LL,
      SH_RL,
      SH_RA
   } shkind_e;

   logic [SHW-1:0]  cnt_q, cnt_d;
   shkind_e         kind_q, kind_d;
   logic            is_shift;
   logic [XLEN-1:0] step;

   assign is_shift = is_sll | is_srl | is_sra;

   always_comb begin
      step = res_q;
      unique case (kind_q)
         SH_LL:   step = {res_q[XLEN-2:0], 1'b0};
         SH_RL:   step = {1'b0, res_q[XLEN-1:1]};
         SH_RA:   step = {res_q[XLEN-1], res_q[XLEN-1:1]};
         default: step = res_q;
      endcase
   end
`endif

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      ill_d   = ill_q;
`ifndef SHIFT_BARREL_EN
      cnt_d   = cnt_q;
      kind_d  = kind_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               res_d   = alu_res;
               ill_d   = ~is_legal;
               state_d = S_DONE;
`ifndef SHIFT_BARREL_EN
               if (is_shift && shamt != '0) begin
                  state_d = S_SHIFT;
                  cnt_d   = shamt;
                  unique case (1'b1)
                     is_srl:  kind_d = SH_RL;
                     is_sra:  kind_d = SH_RA;
                     default: kind_d = SH_LL;
                  endcase
               end
`endif
            end
         end
         S_SHIFT: begin
`ifndef SHIFT_BARREL_EN
            res_d = step;
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               state_d = S_DONE;
            end
`else
            state_d = S_IDLE;
`endif
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         res_q   <= '0;
         ill_q   <= 1'b0;
`ifndef SHIFT_BARREL_EN
         cnt_q   <= '0;
         kind_q  <= SH_LL;
`endif
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         ill_q   <= ill_d;
`ifndef SHIFT_BARREL_EN
         cnt_q   <= cnt_d;
         kind_q  <= kind_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign result    = res_q;
   assign illegal   = ill_q;

endmodule

// File: tb/tb_riscv_alu_exec.sv
// tb_riscv_alu_exec: directed and randomized checks of riscv_alu_exec
// against a behavioural ALU model (latency, result, illegal, handshake).
module tb_riscv_alu_exec;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        illegal;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   riscv_alu_exec dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .illegal   (illegal),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [3:0] o, input logic [31:0] x,
                                 input logic [31:0] y,
                                 output logic [31:0] r, output logic il,
                                 output int lat);
      int sh;
      sh  = int'(y[4:0]);
      il  = 1'b0;
      lat = 1;
      case (o)
         4'd0: r = x & y;
         4'd1: r = x | y;
         4'd2: r = x + y;
         4'd3: r = x ^ y;
         4'd4: begin r = x << sh; lat = sh + 1; end
         4'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd6: r = x - y;
         4'd7: r = (x < y) ? 32'd1 : 32'd0;
         4'd8: begin r = x >> sh; lat = sh + 1; end
         4'd9: begin r = $unsigned($signed(x) >>> sh); lat = sh + 1; end
         default: begin r = 32'd0; il = 1'b1; end
      endcase
`ifdef SHIFT_BARREL_EN
      lat = 1;
`endif
   endfunction

   // inputs are driven and outputs sampled 1 time unit after a rising edge
   task automatic do_op(input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int stall);
      logic [31:0] er;
      logic        ei;
      int          el;
      int          lat;
      model(o, x, y, er, ei, el);
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      op       = o;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op       = 4'($urandom);
      a        = $urandom;
      b        = $urandom;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, el);
      chk("result", result, er);
      chk("illegal", {31'd0, illegal}, {31'd0, ei});
      chk("busy_done", {31'd0, busy}, 32'd1);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         op       = 4'($urandom);
         a        = $urandom;
         b        = $urandom;
         @(posedge clk); #1;
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_result", result, er);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("consumed_valid", {31'd0, out_valid}, 32'd0);
      chk("consumed_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = 4'd0;
      a         = 32'd0;
      b         = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;

      do_op(4'd2, 32'h7FFF_FFFF, 32'd1, 0);
      do_op(4'd6, 32'd5, 32'd7, 0);
      do_op(4'd5, 32'hFFFF_FFFF, 32'd1, 0);
      do_op(4'd7, 32'hFFFF_FFFF, 32'd1, 0);
      do_op(4'd9, 32'h8000_0000, 32'd31, 0);
      do_op(4'd4, 32'd1, 32'h25, 0);
      do_op(4'd8, 32'hDEAD_BEEF, 32'd0, 0);
      do_op(4'd2, 32'h1234_5678, 32'h1111_1111, 10);
      do_op(4'd15, 32'd3, 32'd4, 0);
      do_op(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

      // reset in the middle of a 20-step logical right shift
      op       = 4'd8;
      a        = 32'hF000_0000;
      b        = 32'd20;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      do_op(4'd2, 32'd2, 32'd2, 0);

      for (int k = 0; k < 200; k++) begin
         do_op(4'($urandom_range(0, 15)), $urandom, $urandom,
               int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
